// File: rtl/pwm_speed_capture.sv
// -----------------------------------------------------------------------------
// pwm_speed_capture
//
// Receive side of the slice-based H-bridge PWM drive. Samples the motor
// enable/PWM line, measures its high time in slices and recovers the 6-bit
// speed code. It also measures the rising-to-rising period and flags a line
// stuck high (100 % duty) or stuck low (stopped).
//
// Parameters
//   SLICE_LOG2    log2 of one slice in sysclk cycles
//   CNT_W         width of the high-time, period and idle counters
//   TIMEOUT_LOG2  an edge-free interval of 2^TIMEOUT_LOG2 cycles means the
//                 line is stuck (must be < CNT_W)
//
// Ports
//   sysclk        system clock, all logic on the rising edge
//   rst_n         asynchronous active-low reset
//   pwm_in        asynchronous PWM/enable line
//   speed         decoded speed code (0..63)
//   speed_valid   one-cycle pulse when speed is updated
//   period        last rising-to-rising period, in cycles
//   period_valid  one-cycle pulse when period is updated
//   saturated     line stuck high
//   stopped       line stuck low, or no edge seen since reset
// -----------------------------------------------------------------------------
module pwm_speed_capture #(
  parameter int SLICE_LOG2   = 14,
  parameter int CNT_W        = 22,
  parameter int TIMEOUT_LOG2 = 21
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [5:0]       speed,
  output logic             speed_valid,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             saturated,
  output logic             stopped
);

  // state | meaning
  // ------+--------------------------------------------------------------
  // IDLE  | no reference rise yet (after reset or a stuck-low timeout)
  // HIGH  | line high, counting high time and period
  // LOW   | line low, counting the rest of the period
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // The timeout fires in the cycle the idle timer sits one below
  // 2^TIMEOUT_LOG2, so the registered flags appear as it reaches that value.
  localparam logic [CNT_W-1:0] IDLE_LAST =
    {{(CNT_W-TIMEOUT_LOG2){1'b0}}, {TIMEOUT_LOG2{1'b1}}};

  // Half a slice, used to round the high time to the nearest slice.
  localparam logic [CNT_W:0] HALF_SLICE =
    {{(CNT_W+1-SLICE_LOG2){1'b0}}, 1'b1, {(SLICE_LOG2-1){1'b0}}};

  localparam logic [CNT_W:0] Q_MAX = (CNT_W+1)'(64);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge detect
  // ---------------------------------------------------------------------------
  logic r_sync1;
  logic r_p_s;
  logic r_p_d;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_p_s   <= 1'b0;
      r_p_d   <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_p_s   <= r_sync1;
      r_p_d   <= r_p_s;
    end
  end

  logic w_rise;
  logic w_fall;
  logic w_edge;

  assign w_rise = r_p_s & ~r_p_d;
  assign w_fall = ~r_p_s & r_p_d;
  assign w_edge = w_rise | w_fall;

  // ---------------------------------------------------------------------------
  // Idle timer
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_idle_cnt;
  logic             w_timeout;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if (w_edge) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= sat_inc(r_idle_cnt);
    end
  end

  // An edge in the same cycle wins over the timeout.
  assign w_timeout = ~w_edge && (r_idle_cnt == IDLE_LAST);

  // ---------------------------------------------------------------------------
  // Speed decode: round high time to slices, clamp to 1..64, subtract one
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_hi_cnt;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W:0]   w_round_sum;
  logic [CNT_W:0]   w_q;
  logic [5:0]       w_speed_dec;

  // One extra bit keeps the rounding add from overflowing a saturated count.
  assign w_round_sum = {1'b0, r_hi_cnt} + HALF_SLICE;
  assign w_q         = w_round_sum >> SLICE_LOG2;

  always_comb begin
    w_speed_dec = 6'd0;
    if (w_q >= Q_MAX) begin
      w_speed_dec = 6'd63;
    end else if (w_q != '0) begin
      w_speed_dec = w_q[5:0] - 6'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM, counters and outputs
  // ---------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [5:0]       r_speed;
  logic             r_speed_valid;
  logic [CNT_W-1:0] r_period;
  logic             r_period_valid;
  logic             r_saturated;
  logic             r_stopped;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_hi_cnt       <= '0;
      r_per_cnt      <= '0;
      r_speed        <= 6'd0;
      r_speed_valid  <= 1'b0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_saturated    <= 1'b0;
      r_stopped      <= 1'b1;
    end else begin
      r_speed_valid  <= 1'b0;
      r_period_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          // The first rise only arms the period measurement.
          if (w_rise) begin
            r_state   <= ST_HIGH;
            r_hi_cnt  <= CNT_ONE;
            r_per_cnt <= CNT_ONE;
            r_stopped <= 1'b0;
          end
        end

        ST_HIGH: begin
          // The period counter keeps running through the fall cycle so that
          // it equals the rise-to-rise distance at the next rise.
          r_per_cnt <= sat_inc(r_per_cnt);
          if (w_fall) begin
            r_state       <= ST_LOW;
            r_speed       <= w_speed_dec;
            r_speed_valid <= 1'b1;
            r_saturated   <= 1'b0;
          end else begin
            r_hi_cnt <= sat_inc(r_hi_cnt);
            if (w_timeout && !r_saturated) begin
              r_saturated   <= 1'b1;
              r_speed       <= 6'd63;
              r_speed_valid <= 1'b1;
            end
          end
        end

        ST_LOW: begin
          if (w_rise) begin
            r_state        <= ST_HIGH;
            r_period       <= r_per_cnt;
            r_period_valid <= 1'b1;
            r_hi_cnt       <= CNT_ONE;
            r_per_cnt      <= CNT_ONE;
            r_stopped      <= 1'b0;
          end else if (w_timeout) begin
            r_state   <= ST_IDLE;
            r_stopped <= 1'b1;
          end else begin
            r_per_cnt <= sat_inc(r_per_cnt);
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign speed        = r_speed;
  assign speed_valid  = r_speed_valid;
  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign saturated    = r_saturated;
  assign stopped      = r_stopped;

endmodule

// File: doc/pwm_speed_capture.md
Name: pwm_speed_capture

Overview:
- Receive-side counterpart of the slice-based H-bridge PWM drive.
- Samples a motor enable/PWM line and measures its high time in slices.
- Recovers the 6-bit speed code, the rising-to-rising period, and stuck-line conditions.
- Used for closed-loop checking of the drive output and for decoding PWM commands arriving from an external controller.

Parameters:
SLICE_LOG2, 14, log2 of slice length in sysclk cycles (16384 = 1/64 of the 2^20-cycle period)
CNT_W, 22, width of the high-time, period and idle counters
TIMEOUT_LOG2, 21, an edge-free interval of 2^TIMEOUT_LOG2 cycles declares the line stuck (must be < CNT_W)

Ports:
sysclk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
pwm_in  in  1  asynchronous PWM/enable line
speed  out  6  decoded speed code
speed_valid  out  1  one-cycle pulse when speed is updated
period  out  CNT_W  last measured rising-to-rising period, in cycles
period_valid  out  1  one-cycle pulse when period is updated
saturated  out  1  line stuck high (100% duty)
stopped  out  1  line stuck low, or no edge seen since reset

Behaviour:
- Clocking and reset: one clock (sysclk); reset is asynchronous, active-low (rst_n).
- Reset values: speed=0, period=0, speed_valid=0, period_valid=0, saturated=0, stopped=1, FSM=IDLE, all counters 0, synchronizer flops 0.
- Input path: pwm_in passes through a 2-flop synchronizer into p_s, then a third flop p_d.
  - rise = p_s & ~p_d; fall = ~p_s & p_d.
  - All latencies below are counted from the cycle rise/fall is asserted.
- FSM states:
  - IDLE: wait for rise; on rise go to HIGH with hi_cnt=1 and per_cnt=1. No period is reported from IDLE.
  - HIGH: hi_cnt and per_cnt increment each cycle. On fall go to LOW and compute speed.
  - LOW: per_cnt increments each cycle. On rise go to HIGH, report the period, then set hi_cnt=1 and per_cnt=1.
- Speed decode, registered on the cycle after fall:
  - q = (hi_cnt + 2^(SLICE_LOG2-1)) >> SLICE_LOG2 (round to nearest slice).
  - q is clamped to 1..64; speed = q-1.
  - speed_valid pulses in that same cycle.
- Period report, registered on the cycle after a rise that arrives in LOW:
  - period = per_cnt, and period_valid pulses.
  - A rise from IDLE never reports a period.
- Counter width: all counters saturate at all-ones and never wrap.
- Idle timer: cleared on every rise or fall, incremented otherwise.
- Timeout while in HIGH, on the cycle idle timer reaches 2^TIMEOUT_LOG2:
  - saturated=1, speed=63, one speed_valid pulse.
  - FSM stays in HIGH; no further pulses while stuck.
- Timeout while in LOW:
  - stopped=1, FSM goes to IDLE.
  - speed holds its value; no pulse.
- Flag clearing: saturated clears on the next fall; stopped clears on the next rise.
- Recovery from a stuck-high timeout: the fall that follows decodes normally from the saturated hi_cnt, giving speed=63.
- Simultaneous events: rise and fall cannot coincide after synchronization. A timeout and an edge in the same cycle: the edge wins and the timer clears.
- Reset mid-period: everything returns to reset values immediately; the first period after release is discarded (IDLE).
- speed_valid and period_valid never assert in the same cycle, since fall and rise are at least 1 cycle apart.

Test Plan:
- Bench parameters: SLICE_LOG2=4, TIMEOUT_LOG2=12, CNT_W=22.
- Steady PWM, 160 cycles high / 864 cycles low, repeated 3 times:
  - speed=9 with speed_valid 1 cycle after each fall.
  - period=1024 with period_valid from the 2nd rise onward; stopped clears at the first rise.
- Duty sweep with high times 16, 23, 24, 1024 cycles (1-cycle low gap after the 1024-cycle case):
  - speeds 0, 0, 1, 63.
  - 8-cycle high pulse clamps to speed=0.
- Hold pwm_in high for 5000 cycles after a rise:
  - saturated=1 and speed=63 with one speed_valid exactly 4096 cycles after the last edge.
  - Then drive low: saturated=0, speed=63 pulse.
- Hold pwm_in low for 5000 cycles mid-run:
  - stopped=1 at 4096 cycles, speed unchanged, no pulses.
  - Next rise clears stopped; the following period is not reported until the second rise.
- Assert rst_n low mid-HIGH phase:
  - All outputs return to reset values asynchronously; stopped=1.
  - After release, a partial first pulse yields no period_valid.
- 1-cycle glitches on pwm_in at 1 cycle per 10:
  - Either no edge is detected or speed=0 is decoded.
  - No X values; no counter wrap.
